lock_input_cond: RTL and testbench

Input-conditioning stage directly upstream of the fsm-lock block on the Arty A7-35T. Takes raw board buttons and switches (onoff, oops, enter, login[3:0]) and synchronises them to clk. Debounces each signal and delivers clean levels plus single-cycle press pulses to the lock's onoff/oops/enter/login inputs. One instance per design, between the top-level pins and the lock FSM.

---
 rtl/lock_input_cond_pkg.sv | 22 ++
 rtl/lock_input_cond_if.sv | 25 ++
 rtl/lock_input_cond_debounce.sv | 52 +++++
 rtl/lock_input_cond.sv | 94 +++++++++
 tb/tb_lock_input_cond.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_input_cond_pkg.sv
// Shared constants for the lock input-conditioning stage and the lock FSM.
// Defines debounce defaults, input bit indices and the login width.
package lock_pkg;

    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int CNT_W_DEF      = 20;
    localparam int LOGIN_W        = 4;

    localparam int IDX_ONOFF  = 0;
    localparam int IDX_OOPS   = 1;
    localparam int IDX_ENTER  = 2;
    localparam int IDX_LOGIN0 = 3;
    localparam int IDX_LOGIN1 = 4;
    localparam int IDX_LOGIN2 = 5;
    localparam int IDX_LOGIN3 = 6;
    localparam int N_IN       = 7;

    function automatic logic rise_det(input logic cur, input logic prev);
        return cur & ~prev;
    endfunction

endpackage

// File: rtl/lock_input_cond_if.sv
// Raw board inputs and conditioned outputs of lock_input_cond.
// master = board/bench side, slave = conditioning block.
interface lock_input_cond_if;
    import lock_pkg::*;

    logic               onoff_raw;
    logic               oops_raw;
    logic               enter_raw;
    logic [LOGIN_W-1:0] login_raw;
    logic               onoff;
    logic               oops_p;
    logic               enter_p;
    logic [LOGIN_W-1:0] login;

    modport master (
        output onoff_raw, oops_raw, enter_raw, login_raw,
        input  onoff, oops_p, enter_p, login
    );

    modport slave (
        input  onoff_raw, oops_raw, enter_raw, login_raw,
        output onoff, oops_p, enter_p, login
    );

endinterface

// File: rtl/lock_input_cond_debounce.sv
// debounce_bit: 2-flop synchroniser followed by a counting debouncer.
// db only changes after DEB_CYCLES consecutive cycles of disagreement.
module debounce_bit #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = cnt_q;
        // Any agreement resets the count, so bounce restarts the window.
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/lock_input_cond.sv
// Input conditioning for the lock FSM: sync + debounce of 7 raw inputs, press pulses.
// Optional macro LOGIN_CAPTURE_EN latches login on each enter press.
module lock_input_cond
    import lock_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input logic              clk,
    input logic              reset,
    lock_input_cond_if.slave io
);

    logic [N_IN-1:0]    raw_vec;
    logic [N_IN-1:0]    db_vec;
    logic [LOGIN_W-1:0] db_login;

    assign raw_vec[IDX_ONOFF]                = io.onoff_raw;
    assign raw_vec[IDX_OOPS]                 = io.oops_raw;
    assign raw_vec[IDX_ENTER]                = io.enter_raw;
    assign raw_vec[IDX_LOGIN0 +: LOGIN_W]    = io.login_raw;

    for (genvar i = 0; i < N_IN; i++) begin : g_db
        debounce_bit #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_vec[i]),
            .db   (db_vec[i])
        );
    end

    assign db_login = db_vec[IDX_LOGIN0 +: LOGIN_W];

    logic oops_prev_q, oops_prev_d;
    logic enter_prev_q, enter_prev_d;
    logic oops_p_q, oops_p_d;
    logic enter_p_q, enter_p_d;
    logic oops_rise, enter_rise;

    always_comb begin
        oops_prev_d  = db_vec[IDX_OOPS];
        enter_prev_d = db_vec[IDX_ENTER];
        oops_rise    = rise_det(db_vec[IDX_OOPS], oops_prev_q);
        enter_rise   = rise_det(db_vec[IDX_ENTER], enter_prev_q);
        oops_p_d     = oops_rise;
        // A coincident enter press is dropped, not deferred.
        enter_p_d    = enter_rise & ~oops_rise;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oops_prev_q  <= 1'b0;
            enter_prev_q <= 1'b0;
            oops_p_q     <= 1'b0;
            enter_p_q    <= 1'b0;
        end else begin
            oops_prev_q  <= oops_prev_d;
            enter_prev_q <= enter_prev_d;
            oops_p_q     <= oops_p_d;
            enter_p_q    <= enter_p_d;
        end
    end

`ifdef LOGIN_CAPTURE_EN
    logic [LOGIN_W-1:0] login_cap_q, login_cap_d;

    always_comb begin
        login_cap_d = login_cap_q;
        if (enter_p_d) begin
            login_cap_d = db_login;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            login_cap_q <= '0;
        end else begin
            login_cap_q <= login_cap_d;
        end
    end

    assign io.login = login_cap_q;
`else
    assign io.login = db_login;
`endif

    assign io.onoff   = db_vec[IDX_ONOFF];
    assign io.oops_p  = oops_p_q;
    assign io.enter_p = enter_p_q;

endmodule

// File: tb/tb_lock_input_cond.sv
// Self-checking bench for lock_input_cond (DEB_CYCLES=4) against a windowed history model.
// Honours LOGIN_CAPTURE_EN when defined for both DUT and bench.
module tb_lock_input_cond;

    localparam int DEB = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    lock_input_cond_if bus();

    lock_input_cond #(
        .DEB_CYCLES(DEB),
        .CNT_W     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: samples seen at past edges, debounced levels, pending rises.
    logic [6:0] mhist [0:15];
    logic [6:0] mdb;
    logic       m_oops_p, m_enter_p, m_rose_oops, m_rose_enter;
    logic [3:0] m_cap;

    function automatic logic [6:0] raw_vec();
        return {bus.login_raw, bus.enter_raw, bus.oops_raw, bus.onoff_raw};
    endfunction

    function automatic logic [6:0] obs();
        return {bus.onoff, bus.oops_p, bus.enter_p, bus.login};
    endfunction

    function automatic logic [6:0] exp_out();
        logic [3:0] lg;
`ifdef LOGIN_CAPTURE_EN
        lg = m_cap;
`else
        lg = mdb[6:3];
`endif
        return {mdb[0], m_oops_p, m_enter_p, lg};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) mhist[k] = '0;
        mdb = '0;
        m_oops_p = 0; m_enter_p = 0; m_rose_oops = 0; m_rose_enter = 0;
        m_cap = '0;
    endtask

    // Advance one edge, update the model from the inputs sampled at that edge.
    task automatic tick();
        logic [6:0] s, nd;
        logic all_diff;
        @(posedge clk);
        s = raw_vec();
        cyc++;
        if (!reset) begin
            model_reset();
        end else begin
            m_oops_p  = m_rose_oops;
            m_enter_p = m_rose_enter & ~m_rose_oops;
            if (m_enter_p) m_cap = mdb[6:3];
            nd = mdb;
            for (int b = 0; b < 7; b++) begin
                all_diff = 1'b1;
                for (int k = 1; k <= DEB; k++)
                    if (mhist[k][b] == mdb[b]) all_diff = 1'b0;
                if (all_diff) nd[b] = ~mdb[b];
            end
            m_rose_oops  = nd[1] & ~mdb[1];
            m_rose_enter = nd[2] & ~mdb[2];
            mdb = nd;
            for (int k = 15; k > 0; k--) mhist[k] = mhist[k-1];
            mhist[0] = s;
        end
        #1;
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic drive_all(input logic [6:0] v);
        bus.onoff_raw = v[0];
        bus.oops_raw  = v[1];
        bus.enter_raw = v[2];
        bus.login_raw = v[6:3];
    endtask

    task automatic test_reset();
        drive_all(7'h7f);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs() !== 7'h00) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, obs(), 7'h00);
            end
        end
        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
            end
            if (k == 5) begin
                checks++;
                if (bus.onoff !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_onoff_early got=%b exp=0", bus.onoff);
                end
            end
            if (k == 6) begin
                checks++;
                if (bus.onoff !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_onoff_edge6 got=%b exp=1", bus.onoff);
                end
`ifndef LOGIN_CAPTURE_EN
                checks++;
                if (bus.login !== 4'b1111) begin
                    failures++;
                    $display("FAIL reset_login_edge6 got=%b exp=1111", bus.login);
                end
`endif
            end
        end
        drive_all(7'h00);
        settle(12);
    endtask

    task automatic test_clean_press();
        int npulse, at, t0;
        npulse = 0; at = -1;
        bus.enter_raw = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 15; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
            end
            if (bus.enter_p === 1'b1) begin npulse++; at = cyc - t0; end
        end
        bus.enter_raw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.enter_p === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 1 || at != DEB + 3) begin
            failures++;
            $display("FAIL clean_press_pulse count=%0d at=%0d exp count=1 at=%0d", npulse, at, DEB + 3);
        end
    endtask

    task automatic test_bounce();
        int npulse, at, t_last;
        npulse = 0; at = -1; t_last = cyc;
        for (int k = 0; k < 10; k++) begin
            logic v;
            v = ((k / 2) % 2) == 0;
            if (v !== bus.oops_raw && v) t_last = cyc;
            bus.oops_raw = v;
            tick();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
            end
            if (bus.oops_p === 1'b1) begin npulse++; at = cyc - t_last; end
        end
        for (int k = 0; k < 14; k++) begin
            tick();
            if (bus.oops_p === 1'b1) begin npulse++; at = cyc - t_last; end
        end
        checks++;
        if (npulse != 1 || at != DEB + 3) begin
            failures++;
            $display("FAIL bounce_pulse count=%0d at=%0d exp count=1 at=%0d", npulse, at, DEB + 3);
        end
        bus.oops_raw = 1'b0;
        settle(10);
        npulse = 0;
        bus.oops_raw = 1'b1;
        settle(3);
        bus.oops_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.oops_p === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 0 || bus.oops_p !== 1'b0) begin
            failures++;
            $display("FAIL glitch_pulse count=%0d exp=0", npulse);
        end
    endtask

    task automatic test_simultaneous();
        int n_oops, n_enter, t0;
        n_oops = 0; n_enter = 0;
        bus.oops_raw = 1'b1;
        bus.enter_raw = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL simultaneous cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
            end
            if (cyc - t0 == DEB + 3) begin
                checks++;
                if (bus.oops_p !== 1'b1 || bus.enter_p !== 1'b0) begin
                    failures++;
                    $display("FAIL simultaneous_priority oops_p=%b enter_p=%b exp 1/0", bus.oops_p, bus.enter_p);
                end
            end
            if (bus.oops_p === 1'b1) n_oops++;
            if (bus.enter_p === 1'b1) n_enter++;
        end
        checks++;
        if (n_oops != 1 || n_enter != 0) begin
            failures++;
            $display("FAIL simultaneous_count oops=%0d enter=%0d exp 1/0", n_oops, n_enter);
        end
        bus.oops_raw = 1'b0;
        bus.enter_raw = 1'b0;
        settle(10);
    endtask

    task automatic press_enter_checked();
        bus.enter_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL login_press cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
            end
        end
        bus.enter_raw = 1'b0;
        settle(8);
    endtask

    task automatic test_login();
        int t0;
        bus.login_raw = 4'b1111;
        settle(10);
        press_enter_checked();
        bus.login_raw = 4'b1001;
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL login_change cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
            end
            if (cyc - t0 == 5) begin
                checks++;
                if (bus.login !== 4'b1111) begin
                    failures++;
                    $display("FAIL login_early got=%b exp=1111", bus.login);
                end
            end
            if (cyc - t0 == 7) begin
                checks++;
`ifdef LOGIN_CAPTURE_EN
                if (bus.login !== 4'b1111) begin
`else
                if (bus.login !== 4'b1001) begin
`endif
                    failures++;
                    $display("FAIL login_after_change got=%b", bus.login);
                end
            end
        end
        press_enter_checked();
        checks++;
        if (bus.login !== 4'b1001) begin
            failures++;
            $display("FAIL login_after_enter got=%b exp=1001", bus.login);
        end
        bus.login_raw = 4'b0110;
        settle(12);
        checks++;
`ifdef LOGIN_CAPTURE_EN
        if (bus.login !== 4'b1001) begin
            failures++;
            $display("FAIL login_hold got=%b exp=1001", bus.login);
        end
`else
        if (bus.login !== 4'b0110) begin
            failures++;
            $display("FAIL login_track got=%b exp=0110", bus.login);
        end
`endif
        bus.login_raw = 4'b0000;
        settle(10);
    endtask

    task automatic test_reset_mid();
        int npulse, at, t0;
        npulse = 0; at = -1;
        bus.enter_raw = 1'b1;
        settle(4);
        reset = 1'b0;
        model_reset();
        checks++;
        if (obs() !== 7'h00) begin
            failures++;
            $display("FAIL reset_mid_async got=%b exp=0000000", obs());
        end
        settle(2);
        reset = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 14; k++) begin
            tick();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
            end
            if (bus.enter_p === 1'b1) begin npulse++; at = cyc - t0; end
        end
        checks++;
        if (npulse != 1 || at != DEB + 3) begin
            failures++;
            $display("FAIL reset_mid_pulse count=%0d at=%0d exp count=1 at=%0d", npulse, at, DEB + 3);
        end
        bus.enter_raw = 1'b0;
        settle(10);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                logic [6:0] v;
                v = raw_vec();
                v[$urandom_range(0, 6)] ^= 1'b1;
                drive_all(v);
            end
            if ($urandom_range(0, 150) == 0) begin
                reset = 1'b0;
                model_reset();
            end else begin
                reset = 1'b1;
            end
            tick();
            checks++;
            if (obs() !== exp_out()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
            end
        end
        reset = 1'b1;
        drive_all(7'h00);
        settle(10);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        reset = 1'b0;
        drive_all(7'h00);
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_login();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
